// File: rtl/umar316798.sv
// umar316798 -- 8-bit accumulator ALU driven by a rising-edge execute strobe.
//
// One operation runs per rising edge of uio_in[3] while ena is high. The
// opcode (uio_in[2:0]) and operand B (ui_in) are sampled only in that cycle.
// Results and flags change on the same clock edge and are therefore visible
// on the outputs one cycle after the strobe is first sampled high.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   ena      in   1  block enable
//   ui_in    in   8  operand B
//   uio_in   in   8  [2:0] opcode, [3] execute strobe, [7:4] unused
//   uo_out   out  8  accumulator
//   uio_out  out  8  [7] DONE, [6] N, [5] C, [4] Z, [3:0] zero
//   uio_oe   out  8  constant 8'hF0 (upper nibble driven, lower nibble input)

module umar316798 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {
      OP_LOAD = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_XOR  = 3'b101,
      OP_SHL  = 3'b110,
      OP_SHR  = 3'b111
   } op_e;

   logic [7:0] acc_r;
   logic       c_r;
   logic       z_r;
   logic       n_r;
   logic       done_r;
   logic       stb_q_r;

   logic       strobe_s;
   logic       exec_s;
   op_e        op_s;
   logic [8:0] wide_s;
   logic [7:0] acc_nxt_s;
   logic       c_nxt_s;

   // The upper uio_in nibble has no function; fold it into a sink.
   logic       unused_s;
   assign unused_s = &{1'b0, uio_in[7:4]};

   assign strobe_s = uio_in[3];
   assign op_s     = op_e'(uio_in[2:0]);
   // Execute only on a low-to-high strobe transition seen while enabled.
   assign exec_s   = ena & strobe_s & ~stb_q_r;

   // ALU: next accumulator value and carry/borrow for the sampled opcode.
   always_comb begin
      wide_s    = 9'h000;
      acc_nxt_s = acc_r;
      c_nxt_s   = 1'b0;
      case (op_s)
         OP_LOAD: begin
            acc_nxt_s = ui_in;
         end
         OP_ADD: begin
            wide_s    = {1'b0, acc_r} + {1'b0, ui_in};
            acc_nxt_s = wide_s[7:0];
            c_nxt_s   = wide_s[8];
         end
         OP_SUB: begin
            // Bit 8 of the 9-bit difference is the borrow (B > ACC).
            wide_s    = {1'b0, acc_r} - {1'b0, ui_in};
            acc_nxt_s = wide_s[7:0];
            c_nxt_s   = wide_s[8];
         end
         OP_AND: begin
            acc_nxt_s = acc_r & ui_in;
         end
         OP_OR: begin
            acc_nxt_s = acc_r | ui_in;
         end
         OP_XOR: begin
            acc_nxt_s = acc_r ^ ui_in;
         end
         OP_SHL: begin
            acc_nxt_s = {acc_r[6:0], 1'b0};
            c_nxt_s   = acc_r[7];
         end
         OP_SHR: begin
            acc_nxt_s = {1'b0, acc_r[7:1]};
            c_nxt_s   = acc_r[0];
         end
         default: begin
            acc_nxt_s = acc_r;
            c_nxt_s   = 1'b0;
         end
      endcase
   end

   // Strobe history, accumulator, flags and DONE pulse; reset wins over execute.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stb_q_r <= 1'b0;
         acc_r   <= 8'h00;
         c_r     <= 1'b0;
         z_r     <= 1'b0;
         n_r     <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         // The strobe is tracked even when disabled so a strobe already high
         // when ena rises does not count as a new edge.
         stb_q_r <= strobe_s;
         done_r  <= exec_s;
         if (exec_s) begin
            acc_r <= acc_nxt_s;
            c_r   <= c_nxt_s;
            z_r   <= (acc_nxt_s == 8'h00);
            n_r   <= acc_nxt_s[7];
         end else begin
            acc_r <= acc_r;
            c_r   <= c_r;
            z_r   <= z_r;
            n_r   <= n_r;
         end
      end
   end

   assign uo_out  = acc_r;
   assign uio_out = {done_r, n_r, c_r, z_r, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_umar316798.sv
// Self-checking bench for umar316798: directed vector table, hand-written
// multi-cycle sequences and randomized operations against a reference model.

module tb_umar316798;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks;
   int failures;

   // Reference model state (plain integers).
   int acc_m;
   int c_m;

   typedef struct {
      logic [2:0] op;
      logic [7:0] b;
      logic [7:0] acc;
      logic       c;
      logic       z;
      logic       n;
   } vec_t;

   vec_t vecs[12];

   umar316798 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] flags(input logic done, input logic n, input logic c, input logic z);
      return {done, n, c, z, 4'b0000};
   endfunction

   // Reference model: operation semantics computed with integer arithmetic.
   task automatic model_op(input int op, input int b);
      int r;
      r = acc_m;
      case (op)
         0: begin r = b;                      c_m = 0; end
         1: begin r = acc_m + b; c_m = (r > 255) ? 1 : 0; r = r % 256; end
         2: begin c_m = (b > acc_m) ? 1 : 0; r = (acc_m - b + 256) % 256; end
         3: begin r = acc_m & b;              c_m = 0; end
         4: begin r = acc_m | b;              c_m = 0; end
         5: begin r = acc_m ^ b;              c_m = 0; end
         6: begin c_m = (acc_m >= 128) ? 1 : 0; r = (acc_m * 2) % 256; end
         default: begin c_m = acc_m % 2;      r = acc_m / 2; end
      endcase
      acc_m = r;
   endtask

   // Strobe one op, check result + DONE, then drop strobe with junk on the
   // opcode/B lines and check DONE falls while everything else holds.
   task automatic do_exec(input string name, input logic [2:0] op, input logic [7:0] b,
                          input logic [7:0] eacc, input logic ec, input logic ez, input logic en);
      logic [3:0] junk_hi;
      junk_hi = 4'($urandom);
      ena    = 1'b1;
      ui_in  = b;
      uio_in = {junk_hi, 1'b1, op};
      tick();
      check({name, " acc"}, uo_out, eacc);
      check({name, " flags+done"}, uio_out, flags(1'b1, en, ec, ez));
      ui_in  = 8'($urandom);
      uio_in = {4'($urandom), 1'b0, 3'($urandom)};
      tick();
      check({name, " acc hold"}, uo_out, eacc);
      check({name, " done low"}, uio_out, flags(1'b0, en, ec, ez));
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      uio_in = 8'h00;
      ui_in  = 8'h00;
      tick();
      tick();
      rst_n  = 1'b1;
      acc_m  = 0;
      c_m    = 0;
   endtask

   initial begin
      logic [7:0] eacc;
      logic [2:0] rop;
      logic [7:0] rb;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      ena      = 1'b0;
      ui_in    = 8'h00;
      uio_in   = 8'h00;

      vecs[0]  = '{3'b000, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{3'b001, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{3'b000, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{3'b010, 8'h06, 8'hFF, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{3'b011, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{3'b000, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{3'b110, 8'h3C, 8'h02, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{3'b111, 8'hC3, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{3'b100, 8'h80, 8'h81, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{3'b101, 8'hFF, 8'h7E, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{3'b010, 8'h7E, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{3'b001, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1};

      // Reset state.
      do_reset();
      check("reset uo_out", uo_out, 8'h00);
      check("reset uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'hF0);

      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         do_exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].b,
                 vecs[i].acc, vecs[i].c, vecs[i].z, vecs[i].n);
      end

      // Strobe held high 10 cycles: ADD 1 from ACC=0 executes once.
      do_reset();
      ui_in  = 8'h01;
      uio_in = 8'h09;
      tick();
      check("held first acc", uo_out, 8'h01);
      check("held first done", uio_out, flags(1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 9; i++) begin
         tick();
         check("held acc", uo_out, 8'h01);
         check("held done", uio_out, flags(1'b0, 1'b0, 1'b0, 1'b0));
      end
      uio_in = 8'h00;
      tick();
      acc_m = 1;
      c_m   = 0;

      // ena=0: strobe pulse LOAD 55 has no effect.
      ena    = 1'b0;
      ui_in  = 8'h55;
      uio_in = 8'h08;
      tick();
      check("ena0 acc", uo_out, 8'h01);
      check("ena0 done", uio_out, flags(1'b0, 1'b0, 1'b0, 1'b0));
      // Strobe still high as ena rises: no new edge, no execute.
      ena = 1'b1;
      tick();
      check("ena rise acc", uo_out, 8'h01);
      check("ena rise done", uio_out, flags(1'b0, 1'b0, 1'b0, 1'b0));
      uio_in = 8'h00;
      tick();

      // Reset has priority over a simultaneous execute.
      rst_n  = 1'b0;
      ui_in  = 8'h55;
      uio_in = 8'h08;
      tick();
      check("rst prio acc", uo_out, 8'h00);
      check("rst prio uio", uio_out, 8'h00);
      // Strobe held through reset release executes once.
      rst_n = 1'b1;
      tick();
      check("post rst acc", uo_out, 8'h55);
      check("post rst done", uio_out, flags(1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      check("post rst once", uio_out, flags(1'b0, 1'b0, 1'b0, 1'b0));
      uio_in = 8'h00;
      tick();
      acc_m = 8'h55;
      c_m   = 0;

      // Randomized operations against the reference model.
      for (int i = 0; i < 200; i++) begin
         rop = 3'($urandom);
         rb  = 8'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            ena    = 1'b0;
            uio_in = {4'($urandom), 1'b1, rop};
            ui_in  = rb;
            tick();
            uio_in = {4'($urandom), 1'b0, rop};
            tick();
            eacc = 8'(acc_m);
            check("rand ena0 acc", uo_out, eacc);
            check("rand ena0 done", uio_out[7:4],
                  {1'b0, eacc[7], 1'(c_m), (eacc == 8'h00)});
         end else begin
            model_op(int'(rop), int'(rb));
            eacc = 8'(acc_m);
            do_exec("rand", rop, rb, eacc, 1'(c_m), (eacc == 8'h00), eacc[7]);
         end
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            uio_in = 8'h00;
            tick();
            rst_n = 1'b1;
            acc_m = 0;
            c_m   = 0;
            check("rand rst acc", uo_out, 8'h00);
            check("rand rst uio", uio_out, 8'h00);
         end
      end

      // Mid-sequence reset after activity.
      do_exec("pre rst", 3'b000, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      tick();
      check("mid rst acc", uo_out, 8'h00);
      check("mid rst uio", uio_out, 8'h00);
      check("mid rst oe", uio_oe, 8'hF0);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/umar316798.md
UMAR316798 -- requirements
Module: umar316798

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low, named as the codebase names them: clk, rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 ena  input  1  block enable; high = block selected.
REQ-005 ui_in  input  8  operand B.
REQ-006 uio_in  input  8  [2:0] opcode, [3] execute strobe, [7:4] ignored.
REQ-007 uo_out  output  8  accumulator ACC.
REQ-008 uio_out  output  8  [7] DONE, [6] N flag, [5] C flag, [4] Z flag, [3:0] driven 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'hF0: uio[7:4] outputs, uio[3:0] inputs.

Function
REQ-010 The block SHALL be an 8-bit accumulator ALU executing one operation per rising edge of the strobe uio_in[3].
REQ-011 The block SHALL register the strobe each cycle in STB_Q; an execute event SHALL occur in a cycle where ena=1, uio_in[3]=1 and STB_Q=0.
REQ-012 On an execute event, ACC and flags SHALL update at that same clock edge; new values visible on outputs the following cycle (1-cycle latency from strobe sampled high).
REQ-013 Holding the strobe high SHALL NOT repeat the operation; a new op needs strobe low for at least one cycle.
REQ-014 Opcodes: 000 LOAD ACC=B; 001 ADD ACC=ACC+B; 010 SUB ACC=ACC-B; 011 AND; 100 OR; 101 XOR; 110 SHL ACC=ACC<<1; 111 SHR ACC=ACC>>1 (logical, zero fill).
REQ-015 All arithmetic SHALL be modulo 256 (wrap-around).
REQ-016 C flag: ADD = carry out of bit 7; SUB = borrow (1 when B>ACC unsigned); SHL = old ACC[7]; SHR = old ACC[0]; LOAD/AND/OR/XOR clear C to 0.
REQ-017 Z flag SHALL be 1 iff the new ACC is 8'h00; N flag SHALL equal new ACC[7]; both updated on every execute event.
REQ-018 DONE SHALL be high for exactly one clock cycle, in the cycle after each execute event, otherwise low.
REQ-019 With ena=0, no execute event SHALL occur; ACC and flags hold; STB_Q still tracks the strobe, so a strobe already high when ena rises SHALL NOT execute.
REQ-020 uio_in[7:4] and uio_in[2:0] outside an execute event SHALL have no effect.
REQ-021 Opcode and B SHALL be sampled in the execute-event cycle only.

Reset
REQ-022 While rst_n=0 at a clock edge: ACC=8'h00, Z=0, C=0, N=0, DONE=0, STB_Q=0; uo_out=8'h00, uio_out=8'h00 on the next cycle.
REQ-023 Reset SHALL take priority over an execute event in the same cycle (operation discarded).
REQ-024 uio_oe SHALL be 8'hF0 regardless of reset.
REQ-025 With STB_Q=0 after reset, a strobe held high through reset release SHALL execute once in the first cycle with rst_n=1 and ena=1.

Verification
REQ-026 Reset, then check uo_out=00, uio_out=00, uio_oe=F0.
REQ-027 LOAD B=8'hF0, then ADD B=8'h20 -> ACC=8'h10, C=1, Z=0, N=0; DONE pulses one cycle after each op.
REQ-028 LOAD 8'h05, SUB 8'h06 -> ACC=8'hFF, C=1, N=1, Z=0; then AND 8'h00 -> ACC=00, Z=1, C=0.
REQ-029 LOAD 8'h81, SHL -> ACC=8'h02, C=1; SHR -> ACC=8'h01, C=0.
REQ-030 Strobe held high 10 cycles with ADD B=1 from ACC=0 -> ACC=01 (one execution, one DONE pulse).
REQ-031 ena=0 with strobe pulse LOAD 8'h55 -> ACC unchanged, DONE stays 0; reset asserted mid-sequence -> ACC=00 next cycle.
